// File: rtl/eth_speed_pkg.sv
// Shared speed codes, FSM states and speed-to-select mapping for the RGMII TX clock sequencer.
package eth_speed_pkg;

  localparam logic [1:0] SPD_10  = 2'b00;
  localparam logic [1:0] SPD_100 = 2'b01;
  localparam logic [1:0] SPD_1G  = 2'b10;
  localparam logic [1:0] SPD_BAD = 2'b11;

  typedef enum logic [2:0] {
    LINK_DOWN,
    DEBOUNCE,
    QUIESCE,
    SWITCH,
    SETTLE,
    RUN
  } state_t;

  typedef struct packed {
    logic eth_mode;
    logic ena_10;
  } sel_t;

  function automatic sel_t speed_to_sel(input logic [1:0] spd);
    sel_t sel;
    sel.eth_mode = (spd == SPD_1G);
    sel.ena_10   = (spd == SPD_10);
    return sel;
  endfunction

endpackage

// File: rtl/eth_sync2.sv
// Generic two-flop synchroniser for bringing asynchronous status bits into the clk domain.
module eth_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_speed_ctrl.sv
// Link-speed sequencer: debounces PHY status and switches the TX clock mux only under TX reset.
// Optional forced-speed source is enabled by defining ETH_SPEED_FORCE_EN.
module eth_speed_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int RESET_CYCLES    = 16,
  parameter int SETTLE_CYCLES   = 256,
  parameter int CNT_W           = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       link_up,
  input  logic [1:0] phy_speed,
  input  logic [1:0] force_speed,
  input  logic       force_on,
  output logic       eth_mode,
  output logic       ena_10,
  output logic       tx_reset_n,
  output logic       link_ready,
  output logic       busy,
  output logic [7:0] change_cnt
);
  import eth_speed_pkg::*;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic       link_s;
  logic [1:0] phy_speed_s;
  logic [1:0] src_speed;
  logic       status_ok;

  eth_sync2 #(.WIDTH(1)) u_sync_link  (.clk(clk), .reset_n(reset_n), .d(link_up),   .q(link_s));
  eth_sync2 #(.WIDTH(2)) u_sync_speed (.clk(clk), .reset_n(reset_n), .d(phy_speed), .q(phy_speed_s));

`ifdef ETH_SPEED_FORCE_EN
  logic       force_on_s;
  logic [1:0] force_speed_s;

  eth_sync2 #(.WIDTH(1)) u_sync_force_on    (.clk(clk), .reset_n(reset_n), .d(force_on),    .q(force_on_s));
  eth_sync2 #(.WIDTH(2)) u_sync_force_speed (.clk(clk), .reset_n(reset_n), .d(force_speed), .q(force_speed_s));

  assign src_speed = force_on_s ? force_speed_s : phy_speed_s;
`else
  logic unused_force;
  assign unused_force = ^{force_on, force_speed};
  assign src_speed    = phy_speed_s;
`endif

  // Speed 11 is indistinguishable from a dead link as far as the clock mux is concerned.
  assign status_ok = link_s && (src_speed != SPD_BAD);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       applied_q, applied_d;
  sel_t             sel_q, sel_d;
  logic [7:0]       change_cnt_q, change_cnt_d;
  logic             tx_reset_n_d, link_ready_d, busy_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= LINK_DOWN;
      cnt_q        <= '0;
      cand_q       <= SPD_100;
      applied_q    <= SPD_100;
      sel_q        <= '0;
      change_cnt_q <= '0;
      tx_reset_n   <= 1'b0;
      link_ready   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      applied_q    <= applied_d;
      sel_q        <= sel_d;
      change_cnt_q <= change_cnt_d;
      tx_reset_n   <= tx_reset_n_d;
      link_ready   <= link_ready_d;
      busy         <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    applied_d    = applied_q;
    sel_d        = sel_q;
    change_cnt_d = change_cnt_q;

    case (state_q)
      LINK_DOWN: begin
        cnt_d = '0;
        if (status_ok) begin
          state_d = DEBOUNCE;
          cand_d  = src_speed;
        end
      end
      DEBOUNCE: begin
        if (!status_ok) begin
          state_d = LINK_DOWN;
        end else if (src_speed != cand_q) begin
          cand_d = src_speed;
          cnt_d  = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d = '0;
          // A running link that bounced back to its own speed needs no reset pulse.
          if (tx_reset_n && (cand_q == applied_q)) state_d = RUN;
          else                                     state_d = QUIESCE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      QUIESCE: begin
        if (!status_ok) begin
          state_d = LINK_DOWN;
        end else if (cnt_q == RESET_LAST) begin
          state_d = SWITCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SWITCH: begin
        sel_d     = speed_to_sel(cand_q);
        applied_d = cand_q;
        if ((cand_q != applied_q) && (change_cnt_q != 8'hFF)) change_cnt_d = change_cnt_q + 8'd1;
        state_d   = SETTLE;
        cnt_d     = '0;
      end
      SETTLE: begin
        if (!status_ok) begin
          state_d = LINK_DOWN;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!status_ok) begin
          state_d = LINK_DOWN;
        end else if (src_speed != applied_q) begin
          state_d = DEBOUNCE;
          cand_d  = src_speed;
          cnt_d   = '0;
        end
      end
      default: state_d = LINK_DOWN;
    endcase

    // TX reset stays released through a debounce that started from RUN; it drops at QUIESCE.
    tx_reset_n_d = (state_d == RUN) || ((state_d == DEBOUNCE) && tx_reset_n);
    link_ready_d = (state_d == RUN);
    busy_d       = (state_d == DEBOUNCE) || (state_d == QUIESCE) ||
                   (state_d == SWITCH)   || (state_d == SETTLE);
  end

  assign eth_mode   = sel_q.eth_mode;
  assign ena_10     = sel_q.ena_10;
  assign change_cnt = change_cnt_q;

endmodule

// File: tb/tb_eth_speed_ctrl.sv
// Self-checking bench for eth_speed_ctrl with short debounce/reset/settle timings.
module tb_eth_speed_ctrl;

  localparam int DEB    = 8;
  localparam int RST    = 4;
  localparam int SET    = 8;
  localparam int SETTLE_WAIT = 40;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       link_up;
  logic [1:0] phy_speed;
  logic [1:0] force_speed;
  logic       force_on;
  logic       eth_mode;
  logic       ena_10;
  logic       tx_reset_n;
  logic       link_ready;
  logic       busy;
  logic [7:0] change_cnt;

  eth_speed_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_CYCLES(RST),
    .SETTLE_CYCLES(SET),
    .CNT_W(11)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .link_up(link_up),
    .phy_speed(phy_speed),
    .force_speed(force_speed),
    .force_on(force_on),
    .eth_mode(eth_mode),
    .ena_10(ena_10),
    .tx_reset_n(tx_reset_n),
    .link_ready(link_ready),
    .busy(busy),
    .change_cnt(change_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       eth;
    logic       ena;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic       link;
    logic [1:0] spd;
    exp_t       exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[8];
  int   lat, t_fall, t_sel, t_rise;
  logic found, flag_a, flag_b;
  logic [7:0] exp_cnt;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic link, input logic [1:0] spd);
    @(negedge clk);
    link_up   = link;
    phy_speed = spd;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    reset_n     = 1'b0;
    link_up     = 1'b0;
    phy_speed   = 2'b01;
    force_on    = 1'b0;
    force_speed = 2'b00;
    waitCycles(3);
    reset_n = 1'b1;
  endtask

  task automatic checkSteady(input string tag, input exp_t x);
    checkOutput({tag, "_ready"}, link_ready, x.ready);
    checkOutput({tag, "_txrst"}, tx_reset_n, x.ready);
    checkOutput({tag, "_busy"},  busy,       0);
    checkOutput({tag, "_eth"},   eth_mode,   x.eth);
    checkOutput({tag, "_ena10"}, ena_10,     x.ena);
    checkOutput({tag, "_cnt"},   change_cnt, x.cnt);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'b10, '{1'b1, 1'b1, 1'b0, 8'd1}};
    vecs[1] = '{1'b1, 2'b00, '{1'b1, 1'b0, 1'b1, 8'd2}};
    vecs[2] = '{1'b1, 2'b01, '{1'b1, 1'b0, 1'b0, 8'd3}};
    vecs[3] = '{1'b1, 2'b01, '{1'b1, 1'b0, 1'b0, 8'd3}};
    vecs[4] = '{1'b0, 2'b01, '{1'b0, 1'b0, 1'b0, 8'd3}};
    vecs[5] = '{1'b1, 2'b11, '{1'b0, 1'b0, 1'b0, 8'd3}};
    vecs[6] = '{1'b1, 2'b01, '{1'b1, 1'b0, 1'b0, 8'd3}};
    vecs[7] = '{1'b1, 2'b10, '{1'b1, 1'b1, 1'b0, 8'd4}};

    // Reset values while reset is held.
    reset_n = 1'b0; link_up = 1'b0; phy_speed = 2'b01; force_on = 1'b0; force_speed = 2'b00;
    #12;
    checkSteady("reset", '{1'b0, 1'b0, 1'b0, 8'd0});
    doReset();

    // Bring-up: edge 0 is the first edge that samples the new status.
    applyStimulus(1'b1, 2'b10);
    found = 1'b0; lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (link_ready) begin found = 1'b1; lat = c; break; end
    end
    checkOutput("bringup_found", found, 1);
    checkOutput("bringup_latency", lat, 2 + DEB + RST + 1 + SET);
    checkSteady("bringup", '{1'b1, 1'b1, 1'b0, 8'd1});

    // Speed change 1G -> 10M: reset window around the select change.
    applyStimulus(1'b1, 2'b00);
    t_fall = -1; t_sel = -1; t_rise = -1; flag_a = 1'b0;
    for (int c = 0; c < 100 && t_rise < 0; c++) begin
      @(negedge clk);
      if (tx_reset_n && !link_ready) flag_a = 1'b1;
      if (t_fall < 0 && !tx_reset_n) t_fall = c;
      if (t_sel < 0 && ena_10) t_sel = c;
      if (t_fall >= 0 && t_rise < 0 && tx_reset_n) t_rise = c;
    end
    checkOutput("change_debounce_txrst_high", flag_a, 1);
    // Reset low through all of QUIESCE plus the SWITCH cycle before the selects move.
    checkOutput("change_low_before", t_sel - t_fall, RST + 1);
    checkOutput("change_low_after", t_rise - t_sel, SET);
    checkSteady("change", '{1'b1, 1'b0, 1'b1, 8'd2});

    // Glitch at 100M: a 3-cycle excursion to 1G must not disturb the TX clock.
    applyStimulus(1'b1, 2'b01);
    waitCycles(SETTLE_WAIT);
    checkSteady("pre_glitch", '{1'b1, 1'b0, 1'b0, 8'd3});
    applyStimulus(1'b1, 2'b10);
    waitCycles(2);
    applyStimulus(1'b1, 2'b01);
    flag_a = 1'b0; flag_b = 1'b0;
    for (int c = 0; c < SETTLE_WAIT; c++) begin
      @(negedge clk);
      if (!tx_reset_n) flag_a = 1'b1;
      if (busy) flag_b = 1'b1;
    end
    checkOutput("glitch_txrst_low_seen", flag_a, 0);
    checkOutput("glitch_debounce_seen", flag_b, 1);
    checkSteady("glitch", '{1'b1, 1'b0, 1'b0, 8'd3});

    // Link drop during SETTLE after switching to 1G.
    applyStimulus(1'b1, 2'b10);
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (eth_mode) begin found = 1'b1; break; end
    end
    checkOutput("drop_reach_settle", found, 1);
    applyStimulus(1'b0, 2'b10);
    waitCycles(2);
    checkOutput("drop_busy_before_sync", busy, 1);
    waitCycles(1);
    checkSteady("drop", '{1'b0, 1'b1, 1'b0, 8'd4});
    applyStimulus(1'b1, 2'b10);
    waitCycles(SETTLE_WAIT);
    checkSteady("relink", '{1'b1, 1'b1, 1'b0, 8'd4});

    // Invalid speed code with link up never leaves LINK_DOWN.
    applyStimulus(1'b0, 2'b10);
    waitCycles(6);
    applyStimulus(1'b1, 2'b11);
    flag_a = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy || link_ready || tx_reset_n) flag_a = 1'b1;
    end
    checkOutput("invalid_left_link_down", flag_a, 0);

    // Asynchronous reset in QUIESCE.
    applyStimulus(1'b1, 2'b10);
    waitCycles(SETTLE_WAIT);
    checkSteady("pre_quiesce", '{1'b1, 1'b1, 1'b0, 8'd4});
    applyStimulus(1'b1, 2'b00);
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!tx_reset_n) begin found = 1'b1; break; end
    end
    checkOutput("quiesce_reached", found, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 checkSteady("async_reset", '{1'b0, 1'b0, 1'b0, 8'd0});
    doReset();

    // Table-driven vectors through a scoreboard.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].link, vecs[i].spd);
      sb.push_back(vecs[i].exp);
      waitCycles(SETTLE_WAIT);
      e = sb.pop_front();
      checkSteady($sformatf("vec%0d", i), e);
    end

    // Saturation of the change counter.
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 2'b10 : 2'b00);
      exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      sb.push_back('{1'b1, (i % 2 == 0), (i % 2 != 0), exp_cnt});
      waitCycles(30);
      e = sb.pop_front();
      checkOutput($sformatf("sat%0d_cnt", i), change_cnt, e.cnt);
      checkOutput($sformatf("sat%0d_eth", i), eth_mode, e.eth);
    end

`ifdef ETH_SPEED_FORCE_EN
    // Forced 100M overrides a PHY reporting 1G; releasing the force returns to 1G.
    doReset();
    @(negedge clk);
    force_on    = 1'b1;
    force_speed = 2'b01;
    applyStimulus(1'b1, 2'b10);
    waitCycles(SETTLE_WAIT);
    checkSteady("force_on", '{1'b1, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    force_on = 1'b0;
    waitCycles(SETTLE_WAIT);
    checkSteady("force_off", '{1'b1, 1'b1, 1'b0, 8'd1});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
